// File: rtl/prelude_sequencer.sv
// prelude_sequencer
// Run-control and decode sequencer for the 8-bit prelude CPU core.
// It owns the program counter and the instruction latch. It also decodes the
// fetched instruction word into register-file, ALU, condition and I/O controls.
// Each instruction takes two cycles: FETCH latches the ROM word and EXEC
// commits the result.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   run_en              free-run level
//   step_req            one-cycle pulse that executes a single instruction
//   bp_en, bp_addr      breakpoint enable and address
//   rom_data            combinational ROM word at address pc
//   r0_val              register 0 contents, used as the branch target
//   cond_true           condition-engine result for cond_code
//   pc                  program counter / ROM address
//   rf_*                register-file selects, write enable and write source
//   imm, alu_op         immediate and ALU function
//   cond_code           condition select
//   io_rd_stb/io_wr_stb register-6 (I/O) read and write strobes
//   busy, halted        status flags
//   at_break            status flag: stopped at a breakpoint
//   instr_count         count of retired instructions (wraps)
//   state_dbg           current FSM state, for observation
//
// Handshake: there is no valid/ready pair on this block. step_req is a
// single-cycle request that is sampled only in IDLE. run_en is a level.
// Neither request is acknowledged; a request that is not sampled is dropped.
module prelude_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic               step_req,
  input  logic               bp_en,
  input  logic [7:0]         bp_addr,
  input  logic [7:0]         rom_data,
  input  logic [7:0]         r0_val,
  input  logic               cond_true,
  output logic [7:0]         pc,
  output logic               rf_we,
  output logic [2:0]         rf_src_a,
  output logic [2:0]         rf_src_b,
  output logic [2:0]         rf_dst,
  output logic [1:0]         rf_wsel,
  output logic [7:0]         imm,
  output logic [2:0]         alu_op,
  output logic [2:0]         cond_code,
  output logic               io_rd_stb,
  output logic               io_wr_stb,
  output logic               busy,
  output logic               halted,
  output logic               at_break,
  output logic [COUNT_W-1:0] instr_count,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           pc_q, pc_d;
  logic [7:0]           ir_q, ir_d;
  logic                 skip_bp_q, skip_bp_d;
  logic                 halted_q, halted_d;
  logic                 at_break_q, at_break_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  // Decode signals. These are derived from ir_q in every state.
  logic [1:0] opcode;
  logic       we_dec;
  logic       rd6_dec;
  logic       wr6_dec;
  logic       taken;
  logic       halt_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      ir_q       <= 8'h00;
      skip_bp_q  <= 1'b0;
      halted_q   <= 1'b0;
      at_break_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      skip_bp_q  <= skip_bp_d;
      halted_q   <= halted_d;
      at_break_q <= at_break_d;
      cnt_q      <= cnt_d;
    end
  end

  // Instruction field decode.
  always_comb begin
    opcode    = ir_q[7:6];
    we_dec    = 1'b0;
    rd6_dec   = 1'b0;
    wr6_dec   = 1'b0;
    rf_src_a  = 3'd0;
    rf_src_b  = 3'd0;
    rf_dst    = 3'd0;
    rf_wsel   = 2'd0;
    imm       = 8'h00;
    alu_op    = 3'd0;
    cond_code = 3'd0;
    case (opcode)
      2'b00: begin
        rf_dst  = 3'd0;
        imm     = {2'b00, ir_q[5:0]};
        rf_wsel = 2'd0;
        we_dec  = 1'b1;
      end
      2'b01: begin
        rf_src_a = 3'd1;
        rf_src_b = 3'd2;
        rf_dst   = 3'd3;
        alu_op   = ir_q[2:0];
        rf_wsel  = 2'd1;
        we_dec   = 1'b1;
      end
      2'b10: begin
        rf_src_a = ir_q[5:3];
        rf_dst   = ir_q[2:0];
        rf_wsel  = 2'd2;
        we_dec   = 1'b1;
        rd6_dec  = (ir_q[5:3] == 3'd6);
        wr6_dec  = (ir_q[2:0] == 3'd6);
      end
      default: begin
        cond_code = ir_q[2:0];
      end
    endcase
    taken    = (opcode == 2'b11) && cond_true;
    // The self-branch idiom: an "always" branch whose target is its own address.
    halt_hit = (opcode == 2'b11) && (ir_q[2:0] == 3'b100) && (r0_val == pc_q);
  end

  // Next-state logic and gated strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    skip_bp_d  = skip_bp_q;
    halted_d   = halted_q;
    at_break_d = at_break_q;
    cnt_d      = cnt_q;
    rf_we      = 1'b0;
    io_rd_stb  = 1'b0;
    io_wr_stb  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // If run_en and step_req are both high, the step is absorbed into the
        // free run.
        if (run_en || step_req) state_d = S_FETCH;
      end
      S_FETCH: begin
        // skip_bp lets the restart after a breakpoint run the breakpointed
        // instruction instead of stopping on it again.
        if (bp_en && (pc_q == bp_addr) && !skip_bp_q) begin
          state_d    = S_IDLE;
          at_break_d = 1'b1;
          skip_bp_d  = 1'b1;
        end else begin
          ir_d       = rom_data;
          skip_bp_d  = 1'b0;
          at_break_d = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        rf_we     = we_dec;
        io_rd_stb = rd6_dec;
        io_wr_stb = wr6_dec;
        // On a halt the target equals pc, so the pc write leaves pc unchanged.
        pc_d      = (taken || halt_hit) ? r0_val : pc_q + 8'd1;
        cnt_d     = cnt_q + 1'b1;
        if (halt_hit) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (run_en) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted      = halted_q;
  assign at_break    = at_break_q;
  assign instr_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_prelude_sequencer.sv
// Directed testbench for prelude_sequencer.
module tb_prelude_sequencer;

  localparam int COUNT_W = 16;

  logic               clk;
  logic               reset;
  logic               run_en;
  logic               step_req;
  logic               bp_en;
  logic [7:0]         bp_addr;
  logic [7:0]         rom_data;
  logic [7:0]         r0_val;
  logic               cond_true;
  logic [7:0]         pc;
  logic               rf_we;
  logic [2:0]         rf_src_a;
  logic [2:0]         rf_src_b;
  logic [2:0]         rf_dst;
  logic [1:0]         rf_wsel;
  logic [7:0]         imm;
  logic [2:0]         alu_op;
  logic [2:0]         cond_code;
  logic               io_rd_stb;
  logic               io_wr_stb;
  logic               busy;
  logic               halted;
  logic               at_break;
  logic [COUNT_W-1:0] instr_count;
  logic [1:0]         state_dbg;

  logic [7:0] rom [256];

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  prelude_sequencer #(.PC_RESET(8'h00), .COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_en      (run_en),
    .step_req    (step_req),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .rom_data    (rom_data),
    .r0_val      (r0_val),
    .cond_true   (cond_true),
    .pc          (pc),
    .rf_we       (rf_we),
    .rf_src_a    (rf_src_a),
    .rf_src_b    (rf_src_b),
    .rf_dst      (rf_dst),
    .rf_wsel     (rf_wsel),
    .imm         (imm),
    .alu_op      (alu_op),
    .cond_code   (cond_code),
    .io_rd_stb   (io_rd_stb),
    .io_wr_stb   (io_wr_stb),
    .busy        (busy),
    .halted      (halted),
    .at_break    (at_break),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  // Clock and combinational ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[pc];

  // Move one full cycle and land on the falling edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h05;   // imm 5 -> r0
    rom[8'h01] = 8'h83;   // copy r0 -> r3
    rom[8'h02] = 8'hC4;   // always-branch to r0
    rom[8'h03] = 8'h01;
    rom[8'h04] = 8'h02;
    rom[8'h05] = 8'h47;   // ALU op 7
    rom[8'h06] = 8'hB6;   // copy r6 -> r6
    rom[8'h07] = 8'hC4;
    rom[8'h10] = 8'h0A;
    rom[8'h11] = 8'hC4;
    rom[8'h20] = 8'hC4;
    rom[8'h40] = 8'hC1;   // condition 1, not taken
    rom[8'h41] = 8'hC4;
    rom[8'hFF] = 8'h00;   // non-branch at the top of memory
    rom[8'h30] = 8'hC4;   // self-branch once r0 = 0x30

    reset = 1'b0; run_en = 1'b0; step_req = 1'b0; bp_en = 1'b0;
    bp_addr = 8'h00; r0_val = 8'h00; cond_true = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_at_break", at_break, 1'b0);
    chk("rst_count", instr_count, 16'd0);
    chk("rst_we", {rf_we, io_rd_stb, io_wr_stb}, 3'b000);
    reset = 1'b1;
    tick();
    chk("idle_hold", state_dbg, ST_IDLE);

    // Free run: imm 0x05, then copy 0x83
    run_en = 1'b1;
    tick();
    chk("run_fetch", state_dbg, ST_FETCH);
    chk("run_fetch_we", rf_we, 1'b0);
    tick();
    chk("imm_state", state_dbg, ST_EXEC);
    chk("imm_dst", rf_dst, 3'd0);
    chk("imm_val", imm, 8'h05);
    chk("imm_wsel", rf_wsel, 2'd0);
    chk("imm_we", rf_we, 1'b1);
    chk("imm_pc", pc, 8'h00);
    tick();
    chk("run_pc1", pc, 8'h01);
    chk("run_cnt1", instr_count, 16'd1);
    chk("run_fetch2", state_dbg, ST_FETCH);
    tick();
    chk("cp_src", rf_src_a, 3'd0);
    chk("cp_dst", rf_dst, 3'd3);
    chk("cp_wsel", rf_wsel, 2'd2);
    chk("cp_we", rf_we, 1'b1);
    chk("cp_io", {io_rd_stb, io_wr_stb}, 2'b00);
    run_en = 1'b0;
    tick();
    chk("run_pc2", pc, 8'h02);
    chk("run_cnt2", instr_count, 16'd2);
    chk("run_idle", state_dbg, ST_IDLE);
    chk("run_busy0", busy, 1'b0);

    // Branch from 0x02 to 0x10 by single step
    r0_val = 8'h10; cond_true = 1'b1;
    step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    chk("br10_cond", cond_code, 3'd4);
    chk("br10_we", rf_we, 1'b0);
    tick();
    chk("br10_pc", pc, 8'h10);

    // Step at 0x10; a second pulse during FETCH is ignored
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step_busy_f", busy, 1'b1);
    chk("step_fetch", state_dbg, ST_FETCH);
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step_busy_e", busy, 1'b1);
    chk("step_exec", state_dbg, ST_EXEC);
    chk("step_imm", imm, 8'h0A);
    tick();
    chk("step_pc", pc, 8'h11);
    chk("step_busy0", busy, 1'b0);
    chk("step_cnt", instr_count, 16'd4);
    tick(); tick();
    chk("step_ignored_cnt", instr_count, 16'd4);
    chk("step_ignored_st", state_dbg, ST_IDLE);

    // 0x11 -> 0x20, then taken branch at 0x20 to 0x40
    r0_val = 8'h20;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("br20_pc", pc, 8'h20);
    r0_val = 8'h40;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("br40_pc", pc, 8'h40);
    chk("br40_cnt", instr_count, 16'd6);

    // Untaken condition at 0x40
    cond_true = 1'b0;
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("nt_cond", cond_code, 3'd1);
    tick();
    chk("nt_pc", pc, 8'h41);

    // 0x41 -> 0x03, then free run into breakpoint at 0x05
    cond_true = 1'b1; r0_val = 8'h03;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("br03_pc", pc, 8'h03);
    chk("br03_cnt", instr_count, 16'd8);
    bp_en = 1'b1; bp_addr = 8'h05; run_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (at_break) begin
        seen = 1'b1;
        break;
      end
    end
    run_en = 1'b0;
    chk("bp_seen", seen, 1'b1);
    chk("bp_pc", pc, 8'h05);
    chk("bp_state", state_dbg, ST_IDLE);
    chk("bp_cnt", instr_count, 16'd10);
    tick();
    chk("bp_hold_cnt", instr_count, 16'd10);
    chk("bp_hold_flag", at_break, 1'b1);

    // Resume: 0x47 runs, then 0xB6 drives both I/O strobes
    run_en = 1'b1;
    tick();
    chk("res_fetch", state_dbg, ST_FETCH);
    tick();
    chk("alu_op", alu_op, 3'd7);
    chk("alu_srcs", {rf_src_a, rf_src_b, rf_dst}, {3'd1, 3'd2, 3'd3});
    chk("alu_wsel", rf_wsel, 2'd1);
    chk("alu_we", rf_we, 1'b1);
    chk("res_at_break", at_break, 1'b0);
    tick();
    chk("io_pre", {io_rd_stb, io_wr_stb}, 2'b00);
    tick();
    chk("io_both", {io_rd_stb, io_wr_stb}, 2'b11);
    chk("io_sel", {rf_src_a, rf_dst}, {3'd6, 3'd6});
    run_en = 1'b0;
    tick();
    chk("io_post", {io_rd_stb, io_wr_stb}, 2'b00);
    chk("io_pc", pc, 8'h07);
    chk("io_cnt", instr_count, 16'd12);

    // Non-branch at 0xFF wraps pc to 0x00
    bp_en = 1'b0; r0_val = 8'hFF;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("brFF_pc", pc, 8'hFF);
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_cnt", instr_count, 16'd14);

    // Self-branch halt at 0x30
    rom[8'h00] = 8'hC4; r0_val = 8'h30;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    chk("br30_pc", pc, 8'h30);
    run_en = 1'b1;
    tick(); tick(); tick();
    chk("halt_flag", halted, 1'b1);
    chk("halt_state", state_dbg, ST_HALT);
    chk("halt_pc", pc, 8'h30);
    chk("halt_cnt", instr_count, 16'd16);
    chk("halt_busy", busy, 1'b0);
    step_req = 1'b1; tick(); step_req = 1'b0;
    tick(); tick();
    chk("halt_stay", state_dbg, ST_HALT);
    chk("halt_stay_cnt", instr_count, 16'd16);
    run_en = 1'b0;

    // Reset clears halt
    reset = 1'b0;
    #1;
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_pc", pc, 8'h00);
    chk("rst2_state", state_dbg, ST_IDLE);
    chk("rst2_cnt", instr_count, 16'd0);
    tick();
    reset = 1'b1;

    // Reset asserted during EXEC aborts the instruction
    rom[8'h00] = 8'h05;
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("abort_exec", state_dbg, ST_EXEC);
    reset = 1'b0;
    #1;
    chk("abort_pc", pc, 8'h00);
    chk("abort_cnt", instr_count, 16'd0);
    chk("abort_we", rf_we, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_idle", state_dbg, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
